// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers (a, b) operand pairs in a small FIFO and, on
// start, clears the downstream 8x8 MAC and streams exactly len pairs into it.
// Operands are zero whenever no pair is being issued, so the accumulator holds.
module mac_operand_feeder #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic [7:0]       mac_a,
   output logic [7:0]       mac_b,
   output logic             mac_clr,
   output logic             busy,
   output logic             done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [AW:0]      count_q, count_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [7:0]       mac_a_q, mac_a_d;
   logic [7:0]       mac_b_q, mac_b_d;
   logic [7:0]       mem_a_q [DEPTH];
   logic [7:0]       mem_b_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign push     = in_valid && !full;
   assign in_ready = !full;

   assign mac_a   = mac_a_q;
   assign mac_b   = mac_b_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   // The MAC is held cleared for the whole time reset is low, not just after it.
   assign mac_clr = (state_q == S_CLEAR) || !rst;

   // FIFO storage: written on every accepted push, never reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wptr_q] <= in_a;
         mem_b_q[wptr_q] <= in_b;
      end
   end

   // Sequencer next state, pop decision and next MAC operands.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      mac_a_d     = '0;
      mac_b_d     = '0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = len;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = (remaining_q == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            // An empty FIFO issues a zero bubble; remaining is always >= 1 here.
            if (!empty) begin
               pop         = 1'b1;
               mac_a_d     = mem_a_q[rptr_q];
               mac_b_d     = mem_b_q[rptr_q];
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy bookkeeping; push and pop together cancel out.
   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and operand registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         count_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
      end
   end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural 8x8 MAC downstream.
module tb_mac_operand_feeder;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] len;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [7:0] mac_a;
   logic [7:0] mac_b;
   logic       mac_clr;
   logic       busy;
   logic       done;
   logic [15:0] acc;

   int n_tests = 0;
   int n_fail  = 0;

   mac_operand_feeder #(.DEPTH(4), .LEN_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_clr  (mac_clr),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream MAC: synchronous clear, 16-bit wrapping accumulate.
   always_ff @(posedge clk) begin
      if (mac_clr) acc <= '0;
      else         acc <= acc + ({8'd0, mac_a} * {8'd0, mac_b});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_a;
      logic       exp_done;
      rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;

      // ---------------- reset state
      tick();
      tick();
      chk("rst_mac_clr", mac_clr, 1);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", dut.count_q, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_mac_clr", mac_clr, 0);

      // ---------------- basic dot product, len=3
      push(8'd2, 8'd3);
      push(8'd4, 8'd5);
      push(8'd6, 8'd7);
      chk("t1_count", dut.count_q, 3);
      chk("t1_ready", in_ready, 1);
      start = 1'b1; len = 8'd3;
      tick();                       // cycle 1
      start = 1'b0;
      chk("t1_c1_clr", mac_clr, 1);
      chk("t1_c1_busy", busy, 1);
      tick();                       // cycle 2
      chk("t1_c2_clr", mac_clr, 0);
      chk("t1_c2_a", mac_a, 0);
      tick();                       // cycle 3
      chk("t1_c3_a", mac_a, 2);
      chk("t1_c3_b", mac_b, 3);
      tick();                       // cycle 4
      chk("t1_c4_a", mac_a, 4);
      chk("t1_c4_b", mac_b, 5);
      tick();                       // cycle 5
      chk("t1_c5_a", mac_a, 6);
      chk("t1_c5_b", mac_b, 7);
      chk("t1_c5_done", done, 0);
      tick();                       // cycle 6
      chk("t1_c6_done", done, 1);
      chk("t1_c6_acc", acc, 68);
      chk("t1_c6_a", mac_a, 0);
      tick();                       // cycle 7
      chk("t1_c7_busy", busy, 0);
      chk("t1_c7_done", done, 0);

      // ---------------- fill to full, partial consumption, leftovers
      push(8'd1, 8'd2);
      push(8'd3, 8'd4);
      push(8'd5, 8'd6);
      chk("t2_ready3", in_ready, 1);
      push(8'd7, 8'd8);
      chk("t2_ready4", in_ready, 0);
      push(8'd9, 8'd9);             // refused while full
      chk("t2_full_count", dut.count_q, 4);
      start = 1'b1; len = 8'd2;
      tick();                       // cycle 1
      start = 1'b0;
      chk("t2_c1_ready", in_ready, 0);
      tick();                       // cycle 2
      chk("t2_c2_ready", in_ready, 0);
      tick();                       // cycle 3
      chk("t2_c3_ready", in_ready, 1);
      chk("t2_c3_a", mac_a, 1);
      tick();                       // cycle 4
      chk("t2_c4_a", mac_a, 3);
      chk("t2_c4_b", mac_b, 4);
      tick();                       // cycle 5
      chk("t2_c5_done", done, 1);
      chk("t2_c5_acc", acc, 14);
      chk("t2_c5_count", dut.count_q, 2);
      tick();                       // cycle 6
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0;
      tick();
      tick();                       // cycle 3
      chk("t2b_c3_a", mac_a, 5);
      chk("t2b_c3_b", mac_b, 6);
      tick();
      chk("t2b_c4_a", mac_a, 7);
      tick();                       // cycle 5
      chk("t2b_c5_done", done, 1);
      chk("t2b_c5_acc", acc, 86);
      chk("t2b_c5_count", dut.count_q, 0);
      tick();

      // ---------------- empty FIFO, trickle feed (255,255) every 3 cycles
      start = 1'b1; len = 8'd4;
      for (int k = 1; k <= 14; k++) begin
         tick();
         start    = 1'b0;
         exp_a    = (k == 4 || k == 7 || k == 10 || k == 13) ? 8'd255 : 8'd0;
         exp_done = (k == 14);
         chk($sformatf("t3_c%0d_a", k), mac_a, exp_a);
         chk($sformatf("t3_c%0d_done", k), done, exp_done);
         in_valid = (k == 2 || k == 5 || k == 8 || k == 11);
         in_a     = 8'd255;
         in_b     = 8'd255;
      end
      chk("t3_acc", acc, 63492);
      in_valid = 1'b0;
      tick();
      chk("t3_idle_busy", busy, 0);

      // ---------------- len=0, start while busy, start in DONE, restart in IDLE
      push(8'd10, 8'd10);
      start = 1'b1; len = 8'd0;
      tick();                       // cycle 1
      chk("t4_c1_clr", mac_clr, 1);
      len = 8'd5;                   // start still high while busy
      tick();                       // cycle 2
      chk("t4_c2_done", done, 1);
      chk("t4_c2_acc", acc, 0);
      chk("t4_c2_clr", mac_clr, 0);
      chk("t4_c2_count", dut.count_q, 1);
      len = 8'd1;                   // start still high in DONE
      tick();                       // cycle 3: IDLE, start accepted here
      chk("t4_c3_busy", busy, 0);
      chk("t4_c3_clr", mac_clr, 0);
      tick();                       // CLEAR of the new run
      start = 1'b0;
      chk("t4_restart_clr", mac_clr, 1);
      tick();
      tick();
      chk("t4_restart_a", mac_a, 10);
      tick();
      chk("t4_restart_done", done, 1);
      chk("t4_restart_acc", acc, 100);
      tick();

      // ---------------- reset in the middle of RUN
      push(8'd1, 8'd1);
      push(8'd2, 8'd2);
      push(8'd3, 8'd3);
      push(8'd4, 8'd4);
      start = 1'b1; len = 8'd4;
      tick();                       // cycle 1
      start = 1'b0;
      tick();
      tick();
      tick();                       // cycle 4: pair 2 on the bus, 2 remaining
      chk("t5_c4_a", mac_a, 2);
      chk("t5_c4_count", dut.count_q, 2);
      rst = 1'b0;
      #1;
      chk("t5_clr_comb", mac_clr, 1);
      tick();
      chk("t5_rst_a", mac_a, 0);
      chk("t5_rst_b", mac_b, 0);
      chk("t5_rst_count", dut.count_q, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_clr", mac_clr, 1);
      tick();
      chk("t5_rst_clr_held", mac_clr, 1);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("t5_post_done%0d", k), done, 0);
      end
      chk("t5_post_busy", busy, 0);
      chk("t5_post_ready", in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Upstream sequencer for the 8x8 MAC unit. Buffers incoming (a, b) operand pairs in a small FIFO and, on a start command, clears the MAC and streams exactly `len` pairs into it, one per clock. In all other cycles it drives zero operands so the accumulator holds its value. It pulses `done` once the MAC's `acc` output holds the finished dot product.

## Interface
- DEPTH, 4, operand FIFO depth in pairs; power of 2, at least 2
- LEN_W, 8, width of the vector-length field
- clk  in  1  single clock, rising-edge
- rst  in  1  synchronous reset, active-low
- start  in  1  begin a dot product; sampled only in IDLE
- len  in  LEN_W  number of pairs to issue; sampled with `start`
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept a pair (= not full)
- in_a  in  8  operand a
- in_b  in  8  operand b
- mac_a  out  8  operand to MAC `a`; registered
- mac_b  out  8  operand to MAC `b`; registered
- mac_clr  out  1  active-high clear, drives MAC `rst`
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; MAC `acc` is final during this cycle

## Operation
- **FIFO push:** a pair is pushed on any edge where `in_valid && in_ready`, in any state, including IDLE (prefetch).
  - `in_ready` = !full.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - No push occurs when the FIFO is full.
  - Read and write pointers wrap modulo DEPTH.
  - Full and empty are distinguished by an occupancy counter of width log2(DEPTH)+1.
- **FSM states:** IDLE, CLEAR, RUN, FLUSH, DONE.
  - IDLE: if `start`, latch `remaining` <= `len` and go to CLEAR.
  - CLEAR (1 cycle): `mac_clr` = 1, `mac_a`/`mac_b` = 0. If `remaining` == 0, go to DONE; otherwise go to RUN.
  - RUN: on each edge where the FIFO is non-empty, pop the head into `mac_a`/`mac_b` and decrement `remaining`. When the pop makes `remaining` 0, go to FLUSH. If the FIFO is empty, load `mac_a`/`mac_b` with 0 and stay in RUN (a bubble: it adds 0 to the accumulator).
  - FLUSH (1 cycle): the last pair is still on `mac_a`/`mac_b`. On exit, load 0 into both and go to DONE.
  - DONE (1 cycle): `done` = 1, operands = 0. Go to IDLE.
- `start` is ignored while `busy`.
- Pairs beyond `len` remain in the FIFO, in order, for the next operation.
- `mac_clr` = (state == CLEAR) | !rst, so the MAC is also cleared while reset is asserted.
- No arithmetic is done here. `remaining` is LEN_W bits wide and never underflows, because the decrement happens only on a pop in RUN with `remaining` >= 1.

## Timing
- **Reset** (edge with `rst` = 0):
  - state = IDLE; FIFO emptied (occupancy 0, pointers 0).
  - `mac_a` = `mac_b` = 0, `busy` = 0, `done` = 0, `in_ready` = 1.
  - `mac_clr` = 1 for as long as `rst` is low.
- **Reset mid-operation:** behaves exactly as a reset from any state. In-flight and buffered pairs are discarded and no `done` is produced.
- **Cycle-level sequence**, with `start` sampled in cycle 0 and a FIFO holding at least `len` pairs:
  - cycle 1: CLEAR.
  - cycles 2 .. len+1: RUN, with pops on the closing edges.
  - pair k (1-based) is on `mac_a`/`mac_b` in cycle k+2.
  - cycle len+2: FLUSH.
  - cycle len+3: DONE, `done` = 1.
  - cycle len+4: IDLE, `busy` = 0.
- Each empty-FIFO cycle in RUN delays `done` by exactly one cycle.
- **len = 0:** CLEAR in cycle 1, `done` in cycle 2, the MAC is left at 0, and the FIFO is untouched.
- **Simultaneous events:**
  - A push in the same cycle as a RUN pop on an empty FIFO does not bypass; the pair is popped on the next edge.
  - A `start` in the DONE cycle is ignored. A `start` in the following IDLE cycle is accepted.
- **Throughput:** one pair per cycle when the FIFO is never empty. Minimum restart interval is len+4 cycles.

## Test plan
- Reset, then prefetch 3 pairs (2,3), (4,5), (6,7); `start` with `len`=3: `mac_clr` high in cycle 1; pairs appear in cycles 3, 4, 5; `done` in cycle 6 with MAC `acc` = 6+20+42 = 68; `busy` low in cycle 7.
- Prefetch until full with DEPTH=4: `in_ready` drops after the 4th push. Start with `len`=2: `in_ready` rises again after the first pop, and pairs 3 and 4 remain for the next run, which yields their products summed.
- Start with `len`=4 and an empty FIFO, then feed 1 pair every 3 cycles, each (255,255): zeros appear between pairs, `done` comes only after the 4th pair, and `acc` = 4*65025 mod 2^16 = 63492.
- `len`=0: `done` in cycle 2, `acc` = 0, FIFO occupancy unchanged. A `start` asserted while `busy` is ignored (no second `mac_clr`).
- Drop `rst` in the middle of RUN with 2 pairs remaining: on the next edge the outputs and occupancy go to 0 and `mac_clr` stays high while reset is held. After release, no `done` appears without a new `start`.
